// File: rtl/warp_dispatcher.sv
// Warp dispatcher: fetches, decodes and broadcasts instructions to NUM_THREADS lanes for one run per start.
// Latency: start at cycle 0 -> INIT 1, EXEC 3,5,..,2n+1, HALT 2n+2, WAIT 2n+3, done pulse 2n+4.
// Backpressure: none on issue; WAIT stalls until every masked lane raises thread_complete; start ignored while busy.
//
// Ports:
//   clk, rst_n                  clock and asynchronous active-low reset
//   start, base_pc, instr_count, thread_mask
//                               run request and its parameters, latched in IDLE
//   imem_rd_en, imem_addr, imem_rdata
//                               instruction memory port; rdata is valid one cycle after rd_en
//   type_instruction, regnum_1, regnum_2, dest_reg, shammt, is_active
//                               broadcast to the functional units
//   thread_complete             per-lane completion from the functional units
//   busy, done, illegal_op      status: not idle, end-of-run pulse, sticky illegal opcode seen
module warp_dispatcher #(
    parameter int NUM_THREADS = 4,
    parameter int ADDR_W      = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_pc,
    input  logic [ADDR_W-1:0]      instr_count,
    input  logic [NUM_THREADS-1:0] thread_mask,
    output logic                   imem_rd_en,
    output logic [ADDR_W-1:0]      imem_addr,
    input  logic [31:0]            imem_rdata,
    output logic [2:0]             type_instruction,
    output logic [4:0]             regnum_1,
    output logic [4:0]             regnum_2,
    output logic [4:0]             dest_reg,
    output logic [5:0]             shammt,
    output logic [NUM_THREADS-1:0] is_active,
    input  logic [NUM_THREADS-1:0] thread_complete,
    output logic                   busy,
    output logic                   done,
    output logic                   illegal_op
);

    localparam logic [2:0] OP_INIT = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_FETCH,
        S_EXEC,
        S_HALT,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [ADDR_W-1:0]      pc;
    logic [ADDR_W-1:0]      count;
    logic [NUM_THREADS-1:0] mask;
    logic                   illegal_q;

    // Instruction word fields; bits [7:0] carry nothing for the lanes.
    logic [2:0] dec_type;
    logic [4:0] dec_dest;
    logic [4:0] dec_rs1;
    logic [4:0] dec_rs2;
    logic [5:0] dec_sh;
    logic       unused_low_bits;

    assign dec_type        = imem_rdata[31:29];
    assign dec_dest        = imem_rdata[28:24];
    assign dec_rs1         = imem_rdata[23:19];
    assign dec_rs2         = imem_rdata[18:14];
    assign dec_sh          = imem_rdata[13:8];
    assign unused_low_bits = ^imem_rdata[7:0];

    // A halt or an out-of-place load-init ends the stream early.
    logic dec_stop;
    assign dec_stop = (dec_type == OP_HALT) || (dec_type == OP_INIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Run context: pc, remaining count, lane mask and the sticky illegal flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= '0;
            count     <= '0;
            mask      <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc        <= base_pc;
                        count     <= instr_count;
                        mask      <= thread_mask;
                        illegal_q <= 1'b0;
                    end
                end
                S_EXEC: begin
                    if (dec_type == OP_INIT) begin
                        illegal_q <= 1'b1;
                    end else if (dec_type != OP_HALT) begin
                        pc    <= pc + ADDR_W'(1);
                        count <= count - ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outside issue cycles the lanes see halt with is_active=0, so nothing
    // in a functional unit can be written.
    always_comb begin
        state_nxt        = state;
        type_instruction = OP_HALT;
        dest_reg         = '0;
        regnum_1         = '0;
        regnum_2         = '0;
        shammt           = '0;
        is_active        = '0;
        imem_rd_en       = 1'b0;
        done             = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_INIT;
            end
            S_INIT: begin
                type_instruction = OP_INIT;
                is_active        = mask;
                state_nxt        = (count != '0) ? S_FETCH : S_HALT;
            end
            S_FETCH: begin
                imem_rd_en = 1'b1;
                state_nxt  = S_EXEC;
            end
            S_EXEC: begin
                is_active = mask;
                if (dec_stop) begin
                    // Issued as a clean halt; illegal load-init is replaced too.
                    state_nxt = S_WAIT;
                end else begin
                    type_instruction = dec_type;
                    dest_reg         = dec_dest;
                    regnum_1         = dec_rs1;
                    regnum_2         = dec_rs2;
                    shammt           = dec_sh;
                    // count still holds the pre-decrement value here.
                    state_nxt = (count != ADDR_W'(1)) ? S_FETCH : S_HALT;
                end
            end
            S_HALT: begin
                is_active = mask;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if ((thread_complete & mask) == mask) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign imem_addr  = pc;
    assign busy       = (state != S_IDLE);
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_warp_dispatcher.sv
module tb_warp_dispatcher;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  base_pc = '0;
    logic [7:0]  instr_count = '0;
    logic [3:0]  thread_mask = '0;
    logic        imem_rd_en;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic [2:0]  type_instruction;
    logic [4:0]  regnum_1, regnum_2, dest_reg;
    logic [5:0]  shammt;
    logic [3:0]  is_active;
    logic [3:0]  tc = '0;
    logic        busy, done, illegal_op;

    logic [31:0] imem [0:255];

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    warp_dispatcher #(.NUM_THREADS(4), .ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_pc(base_pc),
        .instr_count(instr_count), .thread_mask(thread_mask),
        .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .type_instruction(type_instruction), .regnum_1(regnum_1), .regnum_2(regnum_2),
        .dest_reg(dest_reg), .shammt(shammt), .is_active(is_active),
        .thread_complete(tc), .busy(busy), .done(done), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data one cycle after the read strobe.
    always @(posedge clk) if (imem_rd_en) imem_rdata <= imem[imem_addr];

    // Observed bundle: type, dest, rs1, rs2, shammt, is_active, rd_en, busy, done.
    logic [30:0] obs;
    assign obs = {type_instruction, dest_reg, regnum_1, regnum_2, shammt, is_active, imem_rd_en, busy, done};

    function automatic logic [30:0] ev(input logic [2:0] t, input logic [4:0] d, input logic [4:0] r1,
                                       input logic [4:0] r2, input logic [5:0] s, input logic [3:0] a,
                                       input logic rd, input logic b, input logic dn);
        return {t, d, r1, r2, s, a, rd, b, dn};
    endfunction

    function automatic logic [31:0] mkw(input logic [2:0] t, input logic [4:0] d, input logic [4:0] r1,
                                        input logic [4:0] r2, input logic [5:0] s);
        return {t, d, r1, r2, s, 8'hA5};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Called 1 time unit after a rising edge while idle; returns in cycle 1 (INIT).
    task automatic start_run(input logic [7:0] pc, input logic [7:0] n, input logic [3:0] m);
        base_pc     = pc;
        instr_count = n;
        thread_mask = m;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 1;
    endtask

    task automatic test_reset();
        logic [30:0] exp;
        exp = ev(3'b111, 0, 0, 0, 0, 4'b0000, 0, 0, 0);
        #1;
        if (obs !== exp) begin $display("FAIL reset_in: got %h want %h", obs, exp); nerr++; end
        nchk++;
        if ({imem_addr, illegal_op} !== 9'd0) begin
            $display("FAIL reset_addr_ill: got %h/%b want 00/0", imem_addr, illegal_op); nerr++;
        end
        nchk++;
        #12 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (obs !== exp) begin $display("FAIL reset_idle c%0d: got %h want %h", i, obs, exp); nerr++; end
            nchk++;
        end
    endtask

    task automatic test_normal();
        logic [30:0] exp;
        logic [7:0]  ea;
        tc = 4'b1011;
        start_run(8'h10, 8'd3, 4'b1011);
        for (int c = 1; c <= 11; c++) begin
            case (c)
                1:        exp = ev(3'b110, 0, 0, 0, 0, 4'b1011, 0, 1, 0);
                2, 4, 6:  exp = ev(3'b111, 0, 0, 0, 0, 4'b0000, 1, 1, 0);
                3:        exp = ev(3'b000, 5'd3, 5'd1, 5'd2, 6'd0, 4'b1011, 0, 1, 0);
                5:        exp = ev(3'b001, 5'd4, 5'd5, 5'd6, 6'd7, 4'b1011, 0, 1, 0);
                7:        exp = ev(3'b010, 5'd31, 5'd17, 5'd9, 6'd63, 4'b1011, 0, 1, 0);
                8:        exp = ev(3'b111, 0, 0, 0, 0, 4'b1011, 0, 1, 0);
                9:        exp = ev(3'b111, 0, 0, 0, 0, 4'b0000, 0, 1, 0);
                10:       exp = ev(3'b111, 0, 0, 0, 0, 4'b0000, 0, 1, 1);
                default:  exp = ev(3'b111, 0, 0, 0, 0, 4'b0000, 0, 0, 0);
            endcase
            if (obs !== exp) begin $display("FAIL normal c%0d: got %h want %h", c, obs, exp); nerr++; end
            nchk++;
            if (c >= 2 && c <= 7) begin
                ea = 8'h10 + 8'((c - 2) / 2);
                if (imem_addr !== ea) begin $display("FAIL normal_addr c%0d: got %h want %h", c, imem_addr, ea); nerr++; end
                nchk++;
            end
            if (c < 11) tick();
        end
        if (illegal_op !== 1'b0) begin $display("FAIL normal_ill: got %b want 0", illegal_op); nerr++; end
        nchk++;
    endtask

    task automatic test_zero_count();
        logic [30:0] exp;
        tc = 4'b0011;
        start_run(8'h40, 8'd0, 4'b0011);
        for (int c = 1; c <= 5; c++) begin
            case (c)
                1:       exp = ev(3'b110, 0, 0, 0, 0, 4'b0011, 0, 1, 0);
                2:       exp = ev(3'b111, 0, 0, 0, 0, 4'b0011, 0, 1, 0);
                3:       exp = ev(3'b111, 0, 0, 0, 0, 4'b0000, 0, 1, 0);
                4:       exp = ev(3'b111, 0, 0, 0, 0, 4'b0000, 0, 1, 1);
                default: exp = ev(3'b111, 0, 0, 0, 0, 4'b0000, 0, 0, 0);
            endcase
            if (obs !== exp) begin $display("FAIL zero_count c%0d: got %h want %h", c, obs, exp); nerr++; end
            nchk++;
            if (c < 5) tick();
        end
    endtask

    task automatic test_pc_wrap();
        logic [30:0] exp;
        logic [7:0]  ea;
        tc = 4'b0001;
        start_run(8'hFF, 8'd2, 4'b0001);
        for (int c = 1; c <= 9; c++) begin
            case (c)
                1:       exp = ev(3'b110, 0, 0, 0, 0, 4'b0001, 0, 1, 0);
                2, 4:    exp = ev(3'b111, 0, 0, 0, 0, 4'b0000, 1, 1, 0);
                3:       exp = ev(3'b000, 5'd3, 5'd1, 5'd2, 6'd0, 4'b0001, 0, 1, 0);
                5:       exp = ev(3'b001, 5'd4, 5'd5, 5'd6, 6'd7, 4'b0001, 0, 1, 0);
                6:       exp = ev(3'b111, 0, 0, 0, 0, 4'b0001, 0, 1, 0);
                7:       exp = ev(3'b111, 0, 0, 0, 0, 4'b0000, 0, 1, 0);
                8:       exp = ev(3'b111, 0, 0, 0, 0, 4'b0000, 0, 1, 1);
                default: exp = ev(3'b111, 0, 0, 0, 0, 4'b0000, 0, 0, 0);
            endcase
            if (obs !== exp) begin $display("FAIL pc_wrap c%0d: got %h want %h", c, obs, exp); nerr++; end
            nchk++;
            if (c >= 2 && c <= 5) begin
                ea = (c <= 3) ? 8'hFF : 8'h00;
                if (imem_addr !== ea) begin $display("FAIL pc_wrap_addr c%0d: got %h want %h", c, imem_addr, ea); nerr++; end
                nchk++;
            end
            if (c < 9) tick();
        end
    endtask

    task automatic test_early_halt();
        logic [30:0] exp;
        tc = 4'b1111;
        start_run(8'h20, 8'd3, 4'b1111);
        // Halt decoded in cycle 5 goes straight to WAIT (6), then DONE (7).
        for (int c = 1; c <= 8; c++) begin
            case (c)
                1:       exp = ev(3'b110, 0, 0, 0, 0, 4'b1111, 0, 1, 0);
                2, 4:    exp = ev(3'b111, 0, 0, 0, 0, 4'b0000, 1, 1, 0);
                3:       exp = ev(3'b000, 5'd3, 5'd1, 5'd2, 6'd0, 4'b1111, 0, 1, 0);
                5:       exp = ev(3'b111, 0, 0, 0, 0, 4'b1111, 0, 1, 0);
                6:       exp = ev(3'b111, 0, 0, 0, 0, 4'b0000, 0, 1, 0);
                7:       exp = ev(3'b111, 0, 0, 0, 0, 4'b0000, 0, 1, 1);
                default: exp = ev(3'b111, 0, 0, 0, 0, 4'b0000, 0, 0, 0);
            endcase
            if (obs !== exp) begin $display("FAIL early_halt c%0d: got %h want %h", c, obs, exp); nerr++; end
            nchk++;
            if (c < 8) tick();
        end
        if (illegal_op !== 1'b0) begin $display("FAIL early_halt_ill: got %b want 0", illegal_op); nerr++; end
        nchk++;
    endtask

    task automatic test_illegal();
        logic [30:0] exp;
        tc = 4'b0110;
        start_run(8'h30, 8'd1, 4'b0110);
        for (int c = 1; c <= 6; c++) begin
            case (c)
                1:       exp = ev(3'b110, 0, 0, 0, 0, 4'b0110, 0, 1, 0);
                2:       exp = ev(3'b111, 0, 0, 0, 0, 4'b0000, 1, 1, 0);
                3:       exp = ev(3'b111, 0, 0, 0, 0, 4'b0110, 0, 1, 0);
                4:       exp = ev(3'b111, 0, 0, 0, 0, 4'b0000, 0, 1, 0);
                5:       exp = ev(3'b111, 0, 0, 0, 0, 4'b0000, 0, 1, 1);
                default: exp = ev(3'b111, 0, 0, 0, 0, 4'b0000, 0, 0, 0);
            endcase
            if (obs !== exp) begin $display("FAIL illegal c%0d: got %h want %h", c, obs, exp); nerr++; end
            nchk++;
            if (c >= 4 && illegal_op !== 1'b1) begin $display("FAIL illegal_flag c%0d: got %b want 1", c, illegal_op); nerr++; end
            if (c >= 4) nchk++;
            if (c < 6) tick();
        end
        tick();
        tick();
        if (illegal_op !== 1'b1) begin $display("FAIL illegal_sticky: got %b want 1", illegal_op); nerr++; end
        nchk++;
        // Next start clears the flag; a zero mask leaves WAIT after one cycle.
        tc = 4'b0000;
        start_run(8'h00, 8'd0, 4'b0000);
        if (illegal_op !== 1'b0) begin $display("FAIL illegal_clear: got %b want 0", illegal_op); nerr++; end
        nchk++;
        tick(); tick(); tick();
        exp = ev(3'b111, 0, 0, 0, 0, 4'b0000, 0, 1, 1);
        if (obs !== exp) begin $display("FAIL zero_mask_done: got %h want %h", obs, exp); nerr++; end
        nchk++;
        tick();
    endtask

    task automatic test_stall();
        logic [30:0] exp;
        tc = 4'b1011;
        start_run(8'h50, 8'd0, 4'b0100);
        for (int c = 1; c <= 10; c++) begin
            case (c)
                1:       exp = ev(3'b110, 0, 0, 0, 0, 4'b0100, 0, 1, 0);
                2:       exp = ev(3'b111, 0, 0, 0, 0, 4'b0100, 0, 1, 0);
                9:       exp = ev(3'b111, 0, 0, 0, 0, 4'b0000, 0, 1, 1);
                10:      exp = ev(3'b111, 0, 0, 0, 0, 4'b0000, 0, 0, 0);
                default: exp = ev(3'b111, 0, 0, 0, 0, 4'b0000, 0, 1, 0);
            endcase
            if (obs !== exp) begin $display("FAIL stall c%0d: got %h want %h", c, obs, exp); nerr++; end
            nchk++;
            start = (c == 2 || c == 5 || c == 9);
            if (c == 8) tc = 4'b1111;
            if (c < 10) tick();
        end
        start = 1'b0;
        tick();
        exp = ev(3'b111, 0, 0, 0, 0, 4'b0000, 0, 0, 0);
        if (obs !== exp) begin $display("FAIL stall_no_restart: got %h want %h", obs, exp); nerr++; end
        nchk++;
    endtask

    task automatic test_async_reset();
        logic [30:0] exp;
        tc = 4'b1011;
        start_run(8'h10, 8'd3, 4'b1011);
        tick(); tick(); tick(); tick();
        exp = ev(3'b001, 5'd4, 5'd5, 5'd6, 6'd7, 4'b1011, 0, 1, 0);
        if (obs !== exp) begin $display("FAIL areset_pre: got %h want %h", obs, exp); nerr++; end
        nchk++;
        #2 rst_n = 1'b0;
        #1;
        exp = ev(3'b111, 0, 0, 0, 0, 4'b0000, 0, 0, 0);
        if (obs !== exp || imem_addr !== 8'h00) begin
            $display("FAIL areset_now: got %h/%h want %h/00", obs, imem_addr, exp); nerr++;
        end
        nchk++;
        tick();
        if (obs !== exp) begin $display("FAIL areset_hold: got %h want %h", obs, exp); nerr++; end
        nchk++;
        #2 rst_n = 1'b1;
        tick();
        tick();
        if (obs !== exp) begin $display("FAIL areset_idle: got %h want %h", obs, exp); nerr++; end
        nchk++;
        tc = 4'b0001;
        start_run(8'h60, 8'd0, 4'b0001);
        tick(); tick(); tick();
        exp = ev(3'b111, 0, 0, 0, 0, 4'b0000, 0, 1, 1);
        if (obs !== exp) begin $display("FAIL areset_rerun: got %h want %h", obs, exp); nerr++; end
        nchk++;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 32'h0;
        imem[8'h10] = mkw(3'b000, 5'd3, 5'd1, 5'd2, 6'd0);
        imem[8'h11] = mkw(3'b001, 5'd4, 5'd5, 5'd6, 6'd7);
        imem[8'h12] = mkw(3'b010, 5'd31, 5'd17, 5'd9, 6'd63);
        imem[8'hFF] = mkw(3'b000, 5'd3, 5'd1, 5'd2, 6'd0);
        imem[8'h00] = mkw(3'b001, 5'd4, 5'd5, 5'd6, 6'd7);
        imem[8'h20] = mkw(3'b000, 5'd3, 5'd1, 5'd2, 6'd0);
        imem[8'h21] = mkw(3'b111, 5'd9, 5'd8, 5'd7, 6'd5);
        imem[8'h22] = mkw(3'b000, 5'd1, 5'd1, 5'd1, 6'd1);
        imem[8'h30] = mkw(3'b110, 5'd2, 5'd3, 5'd4, 6'd5);

        test_reset();
        test_normal();
        test_zero_count();
        test_pc_wrap();
        test_early_halt();
        test_illegal();
        test_stall();
        test_async_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
